// File: rtl/esfa_cell_if.sv
// esfa_cell_if -- request/response bundle for esfa_cell.
// Request side:  op_valid/op_ready handshake with op_sel, handle, idx, val, meta, is_meta.
// Response side: rsp_valid/rsp_ready handshake with rsp_bool, rsp_value, rsp_ctx, rsp_err.
// master: the requester and response consumer. slave: the cell.
interface esfa_cell_if #(
  parameter int W = 8
);
  logic         op_valid;
  logic         op_ready;
  logic [2:0]   op_sel;
  logic [W-1:0] handle;
  logic [W-1:0] idx;
  logic [W-1:0] val;
  logic [W-1:0] meta;
  logic         is_meta;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_bool;
  logic [W-1:0] rsp_value;
  logic [W-1:0] rsp_ctx;
  logic         rsp_err;

  modport master (
    output op_valid, op_sel, handle, idx, val, meta, is_meta, rsp_ready,
    input  op_ready, rsp_valid, rsp_bool, rsp_value, rsp_ctx, rsp_err
  );

  modport slave (
    input  op_valid, op_sel, handle, idx, val, meta, is_meta, rsp_ready,
    output op_ready, rsp_valid, rsp_bool, rsp_value, rsp_ctx, rsp_err
  );
endinterface

// File: rtl/esfa_cell.sv
// esfa_cell -- single tracking cell with a three-phase request/response handshake.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    esfa_cell_if.slave (op_* request, rsp_* response)
// Ops (op_sel): 0 update, 1 lookup, 2 encode, 3 congrue_up, 4 congrue_down,
//               5 mark_avail, 6 enrank, 7 debug.
// Build option: define ESFA_CELL_DEBUG_EN to enable the debug op (7); otherwise
// op 7 answers with rsp_err=1 and leaves state untouched.
//
// state  | meaning
// S_IDLE | op_ready high, waiting for a request
// S_EXEC | operands latched; result computed and registered at the next edge
// S_RESP | response held until rsp_ready
module esfa_cell #(
  parameter int W          = 8,
  parameter int MAX_HANDLE = 7
) (
  input logic        clk,
  input logic        reset,
  esfa_cell_if.slave bus
);
  localparam logic [W-1:0] MAX_H = W'(MAX_HANDLE);
  localparam logic [W-1:0] ONE   = W'(1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
  state_t state, state_nxt;

  logic [2:0]   op_q;
  logic [W-1:0] handle_q, idx_q, val_q, meta_q;
  logic         is_meta_q;

  logic         arr_def, elt_def;
  logic [W-1:0] code, rank, low, high, index, value;
  logic         rsp_bool_q, rsp_err_q;
  logic [W-1:0] rsp_value_q, rsp_ctx_q;

  logic         n_arr, n_elt;
  logic [W-1:0] n_code, n_rank, n_low, n_high, n_index, n_value;
  logic         n_bool, n_err;
  logic [W-1:0] n_rvalue, n_rctx;
  logic         enc_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.op_valid) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.op_ready  = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_bool  = rsp_bool_q;
  assign bus.rsp_value = rsp_value_q;
  assign bus.rsp_ctx   = rsp_ctx_q;
  assign bus.rsp_err   = rsp_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= '0;
      handle_q  <= '0;
      idx_q     <= '0;
      val_q     <= '0;
      meta_q    <= '0;
      is_meta_q <= 1'b0;
    end else if (state == S_IDLE && bus.op_valid) begin
      op_q      <= bus.op_sel;
      handle_q  <= bus.handle;
      idx_q     <= bus.idx;
      val_q     <= bus.val;
      meta_q    <= bus.meta;
      is_meta_q <= bus.is_meta;
    end
  end

  assign enc_ok = is_meta_q && (meta_q <= MAX_H) && arr_def && (meta_q == handle_q);

  // All conditions read the pre-op state; congrue_down checks the interval
  // against the already-adjusted bounds so an emptied range retires the cell.
  always_comb begin
    n_arr    = arr_def;
    n_elt    = elt_def;
    n_code   = code;
    n_rank   = rank;
    n_low    = low;
    n_high   = high;
    n_index  = index;
    n_value  = value;
    n_bool   = 1'b0;
    n_err    = 1'b0;
    n_rvalue = '0;
    n_rctx   = '0;
    case (op_q)
      3'd0: begin
        n_bool   = is_meta_q && (meta_q == handle_q);
        n_rvalue = handle_q;
        n_rctx   = handle_q;
        if (is_meta_q && (meta_q == handle_q)) begin
          n_arr   = 1'b1;
          n_elt   = 1'b1;
          n_code  = handle_q;
          n_low   = handle_q;
          n_high  = handle_q;
          n_index = idx_q;
          n_value = val_q;
          n_rank  = ONE;
        end
      end
      3'd1: begin
        n_bool   = (index == idx_q) && is_meta_q && (low <= meta_q) && (meta_q <= high);
        n_rvalue = value;
        n_rctx   = rank;
      end
      3'd2: begin
        n_bool   = enc_ok;
        n_rvalue = code;
        n_rctx   = code;
      end
      3'd3: begin
        if (idx_q == handle_q) begin
          if (is_meta_q) begin
            n_code = meta_q + ONE;
            n_low  = meta_q + ONE;
            n_high = meta_q + ONE;
            n_rank = val_q + ONE;
          end
        end else begin
          if (arr_def && is_meta_q && (code > meta_q)) n_code = code + ONE;
          if (elt_def && is_meta_q) begin
            if (low > meta_q)   n_low  = low + ONE;
            if (high >= meta_q) n_high = high + ONE;
          end
        end
      end
      3'd4: begin
        if ((idx_q == handle_q) && is_meta_q) begin
          n_arr  = 1'b0;
          n_rank = '0;
        end
        if (elt_def && is_meta_q) begin
          if (meta_q < low) begin
            n_low  = low - ONE;
            n_high = high - ONE;
          end else if (meta_q <= high) begin
            n_high = high - ONE;
          end
        end
        if (elt_def && (n_low > n_high)) begin
          n_elt = 1'b0;
          n_arr = 1'b0;
        end
        if (arr_def && is_meta_q && (code > meta_q)) n_code = code - ONE;
      end
      3'd5: begin
        n_bool   = !elt_def;
        n_rvalue = handle_q;
        n_rctx   = handle_q;
      end
      3'd6: begin
        n_bool   = enc_ok;
        n_rvalue = rank;
        n_rctx   = rank;
      end
      default: begin
`ifdef ESFA_CELL_DEBUG_EN
        n_bool   = (meta_q <= MAX_H) && (meta_q == handle_q);
        n_rvalue = high;
        n_rctx   = low;
`else
        n_err    = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arr_def     <= 1'b0;
      elt_def     <= 1'b0;
      code        <= '0;
      rank        <= '0;
      low         <= '0;
      high        <= '0;
      index       <= '0;
      value       <= '0;
      rsp_bool_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_value_q <= '0;
      rsp_ctx_q   <= '0;
    end else if (state == S_EXEC) begin
      arr_def     <= n_arr;
      elt_def     <= n_elt;
      code        <= n_code;
      rank        <= n_rank;
      low         <= n_low;
      high        <= n_high;
      index       <= n_index;
      value       <= n_value;
      rsp_bool_q  <= n_bool;
      rsp_err_q   <= n_err;
      rsp_value_q <= n_rvalue;
      rsp_ctx_q   <= n_rctx;
    end
  end
endmodule

// File: doc/esfa_cell.md
ESFA_CELL -- requirements
Module: esfa_cell

Interface
REQ-001 Parameter W, 8, width of handle, index, value, metadata and result fields.
REQ-002 Parameter MAX_HANDLE, 7, largest metadata value accepted by encode/enrank/debug.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; clears all state immediately on assertion.
REQ-005 op_valid  in  1  request present; op_ready  out  1  cell can accept a request.
REQ-006 op_sel  in  3  0 update, 1 lookup, 2 encode, 3 congrue_up, 4 congrue_down, 5 mark_avail, 6 enrank, 7 debug.
REQ-007 handle, idx, val, meta  in  W each  cell handle, inserted index, inserted value, metadata.
REQ-008 is_meta  in  1  metadata field valid.
REQ-009 rsp_valid  out  1  response held; rsp_ready  in  1  consumer takes response.
REQ-010 rsp_bool  out  1; rsp_value  out  W; rsp_ctx  out  W; rsp_err  out  1  illegal op.

Function
REQ-011 State: arr_def, elt_def (1 bit); code, rank, low, high, index, value (W bits).
REQ-012 FSM IDLE -> EXEC -> RESP -> IDLE; op_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-013 IDLE: on op_valid&&op_ready, operands incl. op_sel latched at edge k, go EXEC; inputs ignored afterwards.
REQ-014 EXEC: at edge k+1 compute from latched operands and current state, register state and all rsp_* outputs, go RESP.
REQ-015 RESP: outputs stable until edge where rsp_ready=1, then IDLE; op_ready high from that edge; min 3 cycles per op.
REQ-016 update: hit=(meta==handle)&&is_meta; on hit arr_def=elt_def=1, code=low=high=handle, index=idx, value=val, rank=1; rsp_bool=hit, rsp_value=rsp_ctx=handle.
REQ-017 lookup: rsp_bool=(index==idx)&&is_meta&&low<=meta<=high; rsp_value=value; rsp_ctx=rank; no state change.
REQ-018 encode: rsp_bool=is_meta&&meta<=MAX_HANDLE&&arr_def&&meta==handle; rsp_value=rsp_ctx=code.
REQ-019 enrank: same rsp_bool as encode; rsp_value=rsp_ctx=rank.
REQ-020 congrue_up, idx==handle&&is_meta: code=low=high=meta+1, rank=val+1.
REQ-021 congrue_up, idx!=handle: if arr_def&&is_meta&&code>meta code+1; if elt_def&&is_meta: low>meta -> low+1, high>=meta -> high+1.
REQ-022 congrue_down: idx==handle&&is_meta clears arr_def, rank=0; elt_def&&is_meta: meta<low -> low-1,high-1; else low<=meta<=high -> high-1.
REQ-023 congrue_down: if elt_def and new low>new high (unsigned) clear elt_def and arr_def; arr_def&&is_meta&&code>meta -> code-1.
REQ-024 mark_avail: rsp_bool=!elt_def; rsp_value=rsp_ctx=handle.
REQ-025 congrue ops: rsp_bool=0, rsp_value=rsp_ctx=0; rsp_err=0 for ops 0-6.
REQ-026 Arithmetic modulo 2^W, no saturation: 2^W-1 +1 = 0, 0 -1 = 2^W-1; comparisons unsigned.
REQ-027 Simultaneous rsp_ready and op_valid at RESP edge: op not accepted that edge.

Reset
REQ-028 Assertion in any state: FSM IDLE, all state fields 0, rsp_valid=0, rsp_bool=rsp_err=0, rsp_value=rsp_ctx=0, op_ready=1 once released.
REQ-029 Reset mid-op discards op; no response issued; first edge after deassertion may accept.

Configuration
REQ-030 Macro ESFA_CELL_DEBUG_EN defined: op 7 gives rsp_bool=meta<=MAX_HANDLE&&meta==handle, rsp_value=high, rsp_ctx=low, rsp_err=0.
REQ-031 Macro undefined: op 7 gives rsp_bool=0, rsp_value=rsp_ctx=0, rsp_err=1, no state change; handshake unchanged.

Verification
REQ-032 W=8, handle=3: update meta=3,is_meta=1,idx=5,val=0x2A -> rsp_bool=1,value=3; lookup idx=5,meta=3 -> bool=1,value=0x2A,ctx=1.
REQ-033 After REQ-032: congrue_up idx=3,meta=4,val=2 -> encode meta=3 gives value 5; enrank gives 3.
REQ-034 low=high=3: congrue_down idx=9,meta=3 -> high=2<low, elt_def=0; mark_avail -> rsp_bool=1.
REQ-035 Hold rsp_ready=0 for 5 cycles -> rsp_* stable, op_ready=0; new op_valid ignored.
REQ-036 reset low during EXEC -> no rsp_valid, state zero; encode after -> rsp_bool=0, value 0.
REQ-037 op 7 with/without ESFA_CELL_DEBUG_EN, meta=handle=3, high=3 -> value 3/err 0 versus value 0/err 1.
